// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the PRBS challenge generator.
// Tap masks use bit i = state bit i, so the feedback tap set always includes the MSB.
package lfsr_pkg;

  localparam int MIN_BITS = 3;
  localparam int MAX_BITS = 32;

  // Maximal-length Fibonacci masks (x^n + ... + 1), one per supported width.
  function automatic logic [MAX_BITS-1:0] max_taps(input int n);
    case (n)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // XOR feedback sticks at all-zeros, XNOR feedback sticks at all-ones.
  function automatic logic [MAX_BITS-1:0] lock_word(input int n, input logic xnor_mode);
    logic [MAX_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_BITS; i++)
      if (i < n) w[i] = xnor_mode;
    return w;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci shift: parity of tapped bits (optionally inverted) enters at bit 0.
module lfsr_step #(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] state,
  input  logic [NUM_BITS-1:0] taps,
  input  logic                cfg_xnor,
  output logic [NUM_BITS-1:0] next
);

  logic fb;

  assign fb   = (^(state & taps)) ^ cfg_xnor;
  assign next = {state[NUM_BITS-2:0], fb};

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Run-time configurable LFSR/PRBS word source with valid/ready output,
// lock-state recovery and measured sequence period.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int                     NUM_BITS     = 8,
  parameter int                     STEP         = 1,
  parameter logic [NUM_BITS-1:0]    DEFAULT_SEED = NUM_BITS'(1),
  parameter logic [NUM_BITS-1:0]    DEFAULT_TAPS = NUM_BITS'(max_taps(NUM_BITS))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_xnor,
  input  logic                taps_DV,
  input  logic [NUM_BITS-1:0] taps,
  input  logic                seed_DV,
  input  logic [NUM_BITS-1:0] seed,
  output logic [NUM_BITS-1:0] LFSR_data,
  output logic                LFSR_valid,
  input  logic                LFSR_ready,
  output logic                LFSR_done,
  output logic [NUM_BITS-1:0] period,
  output logic                lockup
);

  logic [NUM_BITS-1:0]           state, r_seed, r_taps, cnt, cnt_inc, lock, nxt;
  logic [STEP:0][NUM_BITS-1:0]   chain;
  logic                          valid, done, lock_pls, adv;

  // STEP shifts unrolled combinationally; chain[0] is the current word.
  assign chain[0] = state;
  for (genvar g = 0; g < STEP; g++) begin : g_step
    lfsr_step #(.NUM_BITS(NUM_BITS)) u_step (
      .state    (chain[g]),
      .taps     (r_taps),
      .cfg_xnor (cfg_xnor),
      .next     (chain[g+1])
    );
  end
  assign nxt = chain[STEP];

  assign lock    = NUM_BITS'(lock_word(NUM_BITS, cfg_xnor));
  assign adv     = en & valid & LFSR_ready;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + NUM_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DEFAULT_SEED;
      r_seed   <= DEFAULT_SEED;
      r_taps   <= DEFAULT_TAPS;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      lock_pls <= 1'b0;
    end else begin
      valid    <= 1'b1;
      done     <= 1'b0;
      lock_pls <= 1'b0;
      if (taps_DV) r_taps <= taps;
      if (seed_DV) begin
        cnt <= '0;
        if (seed == lock) begin
          state    <= DEFAULT_SEED;
          r_seed   <= DEFAULT_SEED;
          lock_pls <= 1'b1;
        end else begin
          state  <= seed;
          r_seed <= seed;
        end
      end else if (adv) begin
        if (nxt == lock) begin
          state    <= DEFAULT_SEED;
          r_seed   <= DEFAULT_SEED;
          cnt      <= '0;
          lock_pls <= 1'b1;
        end else begin
          state <= nxt;
          if (nxt == r_seed) begin
            done   <= 1'b1;
            period <= cnt_inc;
            cnt    <= '0;
          end else begin
            cnt <= cnt_inc;
            // Sequence that never returns to its seed reports a saturated period.
            if (cnt_inc == '1) period <= '1;
          end
        end
      end
    end
  end

  assign LFSR_data  = state;
  assign LFSR_valid = valid;
  assign LFSR_done  = done;
  assign lockup     = lock_pls;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Randomized self-checking bench for lfsr_prbs_gen against a word-level reference model.
module tb_lfsr_prbs_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, cfg_xnor = 1'b0, taps_dv = 1'b0, seed_dv = 1'b0, ready = 1'b1;
  logic [7:0] taps = 8'hB8, seed = 8'h01;
  logic [7:0] data, period;
  logic       valid, done, lockup;

  logic       en8 = 1'b0, seed_dv8 = 1'b0;
  logic [7:0] seed8 = 8'h01;
  logic [7:0] data8, period8;
  logic       valid8, done8, lockup8;

  int n_chk = 0, n_err = 0;

  // reference model state
  logic [7:0] m_state, m_seed, m_taps, m_period;
  int         m_cnt;
  logic       m_valid, m_done, m_lock;

  always #5 clk = ~clk;

  lfsr_prbs_gen #(.NUM_BITS(8), .STEP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_xnor(cfg_xnor), .taps_DV(taps_dv), .taps(taps),
    .seed_DV(seed_dv), .seed(seed), .LFSR_data(data), .LFSR_valid(valid),
    .LFSR_ready(ready), .LFSR_done(done), .period(period), .lockup(lockup)
  );

  lfsr_prbs_gen #(.NUM_BITS(8), .STEP(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .cfg_xnor(1'b0), .taps_DV(1'b0), .taps(8'h00),
    .seed_DV(seed_dv8), .seed(seed8), .LFSR_data(data8), .LFSR_valid(valid8),
    .LFSR_ready(1'b1), .LFSR_done(done8), .period(period8), .lockup(lockup8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Next word by plain arithmetic: double the word, add the tap parity bit.
  function automatic logic [7:0] shift1(input logic [7:0] s, input logic [7:0] t, input logic x);
    int p;
    p = ($countones(s & t) % 2) ^ int'(x);
    return 8'((int'(s) * 2 + p) % 256);
  endfunction

  task automatic model_edge();
    logic [7:0] lockw, ns;
    int         c1;
    bit         adv;
    if (rst) begin
      m_state = 8'h01; m_seed = 8'h01; m_taps = 8'hB8; m_cnt = 0; m_period = 8'h00;
      m_valid = 1'b0; m_done = 1'b0; m_lock = 1'b0;
    end else begin
      lockw  = cfg_xnor ? 8'hFF : 8'h00;
      adv    = en && m_valid && ready;
      m_done = 1'b0;
      m_lock = 1'b0;
      if (seed_dv) begin
        m_cnt = 0;
        if (seed == lockw) begin m_state = 8'h01; m_seed = 8'h01; m_lock = 1'b1; end
        else begin m_state = seed; m_seed = seed; end
      end else if (adv) begin
        ns = shift1(m_state, m_taps, cfg_xnor);
        if (ns == lockw) begin
          m_state = 8'h01; m_seed = 8'h01; m_cnt = 0; m_lock = 1'b1;
        end else begin
          m_state = ns;
          c1 = (m_cnt >= 255) ? 255 : m_cnt + 1;
          if (ns == m_seed) begin m_done = 1'b1; m_period = 8'(c1); m_cnt = 0; end
          else begin m_cnt = c1; if (c1 == 255) m_period = 8'hFF; end
        end
      end
      if (taps_dv) m_taps = taps;
      m_valid = 1'b1;
    end
  endtask

  // One clock: update the model at the edge, compare the STEP=1 instance just after.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("data",   data,   m_state);
    chk("valid",  valid,  m_valid);
    chk("done",   done,   m_done);
    chk("lockup", lockup, m_lock);
    chk("period", period, m_period);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen [256];
    int         distinct, lock_seen, waited;
    logic [7:0] hold, seq [0:520];
    bit         rdy_pat [4];

    // reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_data", data, 8'h01);
    chk("rst_valid", valid, 1'b0);
    rst = 1'b0;
    cyc();
    chk("valid_rise", valid, 1'b1);

    // full maximal-length cycle from seed 0x01
    en = 1'b1; ready = 1'b1; distinct = 0; lock_seen = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int w = 1; w <= 255; w++) begin
      cyc();
      if (!seen[data]) distinct++;
      seen[data] = 1'b1;
      if (lockup) lock_seen++;
      if (w == 255) chk("done_at_255", done, 1'b1);
      else if (done) chk("early_done", w, 255);
    end
    chk("distinct", distinct, 255);
    chk("period_255", period, 8'd255);
    chk("no_lockup", lock_seen, 0);

    // XNOR mode with the all-ones seed is refused
    en = 1'b0; cfg_xnor = 1'b1; seed = 8'hFF; seed_dv = 1'b1;
    cyc();
    seed_dv = 1'b0;
    chk("xnor_lock_pulse", lockup, 1'b1);
    chk("xnor_lock_data", data, 8'h01);
    chk("xnor_lock_period", period, 8'd255);
    cyc();

    // reset mid-run at word 100
    cfg_xnor = 1'b0; seed = 8'h01; seed_dv = 1'b1;
    cyc();
    seed_dv = 1'b0; en = 1'b1;
    for (int w = 0; w < 100; w++) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_data", data, 8'h01);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_period", period, 8'h00);
    rst = 1'b0;
    cyc();
    chk("midrst_valid_back", valid, 1'b1);

    // backpressure: ready pattern 1,0,0,1 until the sequence closes
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    waited = 0;
    hold = data;
    while (waited < 2000) begin
      ready = rdy_pat[waited % 4];
      hold = data;
      cyc();
      if (!ready) chk("bp_hold", data, hold);
      waited++;
      if (done) break;
    end
    chk("bp_closed", waited < 2000, 1'b1);
    chk("bp_period", period, 8'd255);
    ready = 1'b1;

    // seed + taps + advance in the same cycle
    seed = 8'h33; seed_dv = 1'b1; taps = 8'h8E; taps_dv = 1'b1; en = 1'b1;
    cyc();
    seed_dv = 1'b0; taps_dv = 1'b0;
    chk("same_cyc_seed", data, 8'h33);
    cyc();
    chk("same_cyc_newtaps", data, shift1(8'h33, 8'h8E, 1'b0));
    taps = 8'hB8; taps_dv = 1'b1;
    cyc();
    taps_dv = 1'b0;

    // STEP=8 instance against the single-step sequence from 0x5A
    seq[0] = 8'h5A;
    for (int i = 1; i <= 520; i++) seq[i] = shift1(seq[i-1], 8'hB8, 1'b0);
    en = 1'b0;
    seed8 = 8'h5A; seed_dv8 = 1'b1;
    cyc();
    seed_dv8 = 1'b0; en8 = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      chk($sformatf("step8_k%0d", k), data8, seq[8*k]);
    end
    en8 = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      en      = ($urandom_range(3) != 0);
      ready   = ($urandom_range(3) != 0);
      seed_dv = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0:       seed = 8'h00;
        1:       seed = 8'hFF;
        default: seed = 8'($urandom);
      endcase
      taps_dv = ($urandom_range(31) == 0);
      case ($urandom_range(3))
        0:       taps = 8'hB8;
        1:       taps = 8'h8E;
        default: taps = 8'($urandom);
      endcase
      if ($urandom_range(63) == 0) cfg_xnor = ~cfg_xnor;
      rst = ($urandom_range(499) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
